// File: rtl/shared_fifo_tracker.sv
// shared_fifo_tracker
// Monitor for the shared linked-list FIFO. It keeps per-channel and total
// occupancy, tags one entry on a run-time selected channel and checks that the
// entry leaves that channel with the data it was pushed with. Environment
// violations (overfull push, empty or out-of-range pop) raise a sticky error.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no entry tagged, waiting for start with a qualifying push
// TRACK | tagged entry in flight, ahead = entries still queued before it
// DONE  | tagged entry popped, captured data held until rst
module shared_fifo_tracker #(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 2,
   parameter int NUM_FIFOS = 2,
   parameter int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 push,
   input  logic                                 pop,
   input  logic [SEL_WIDTH-1:0]                 push_sel,
   input  logic [SEL_WIDTH-1:0]                 pop_sel,
   input  logic [WIDTH-1:0]                     data_in,
   input  logic [WIDTH-1:0]                     data_out,
   input  logic                                 start,
   input  logic [SEL_WIDTH-1:0]                 watch_sel,
   output logic [NUM_FIFOS*(PTR_WIDTH+1)-1:0]   count_flat,
   output logic [PTR_WIDTH:0]                   total,
   output logic                                 tracking,
   output logic                                 data_out_vld,
   output logic                                 prop_signal,
   output logic                                 protocol_err
);

   localparam int CW = PTR_WIDTH + 1;
   localparam logic [CW-1:0]        DEPTH_C = CW'(DEPTH);
   localparam logic [SEL_WIDTH:0]   NF_C    = (SEL_WIDTH + 1)'(NUM_FIFOS);

   typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          count_q [NUM_FIFOS];
   logic [CW-1:0]          count_d [NUM_FIFOS];
   logic [CW-1:0]          total_q, total_d;
   logic [CW-1:0]          ahead_q, ahead_d;
   logic [SEL_WIDTH-1:0]   tracked_sel_q, tracked_sel_d;
   logic [WIDTH-1:0]       tracked_data_q, tracked_data_d;
   logic [WIDTH-1:0]       captured_q, captured_d;
   logic                   err_q, err_d;
   logic                   tracking_q, tracking_d;
   logic                   vld_q, vld_d;

   logic push_ok, pop_ok, push_in_range, pop_in_range;

   // Qualify strobes against the occupancy seen at the start of the cycle.
   always_comb begin
      push_in_range = ({1'b0, push_sel} < NF_C);
      pop_in_range  = ({1'b0, pop_sel} < NF_C);
      push_ok       = push && push_in_range && (total_q < DEPTH_C);
      pop_ok        = pop && pop_in_range && (count_q[pop_sel] != '0);
      err_d         = err_q | (push & ~push_ok) | (pop & ~pop_ok);
   end

   // Occupancy bookkeeping; push and pop on one channel cancel.
   always_comb begin
      for (int c = 0; c < NUM_FIFOS; c++) begin
         count_d[c] = count_q[c]
                    + CW'(push_ok && (push_sel == SEL_WIDTH'(c)))
                    - CW'(pop_ok && (pop_sel == SEL_WIDTH'(c)));
      end
      total_d = total_q + CW'(push_ok) - CW'(pop_ok);
   end

   // Tag tracking. A same-cycle pop on the armed channel removes an older
   // entry, so it is taken off ahead at arm time.
   always_comb begin
      state_d        = state_q;
      ahead_d        = ahead_q;
      tracked_sel_d  = tracked_sel_q;
      tracked_data_d = tracked_data_q;
      captured_d     = captured_q;
      case (state_q)
         IDLE: begin
            if (start && push_ok && (push_sel == watch_sel)) begin
               state_d        = TRACK;
               tracked_sel_d  = watch_sel;
               tracked_data_d = data_in;
               ahead_d        = count_q[watch_sel]
                              - CW'(pop_ok && (pop_sel == watch_sel));
            end
         end
         TRACK: begin
            if (pop_ok && (pop_sel == tracked_sel_q)) begin
               if (ahead_q == '0) begin
                  captured_d = data_out;
                  state_d    = DONE;
               end else begin
                  ahead_d = ahead_q - CW'(1);
               end
            end
         end
         default: ;
      endcase
      tracking_d = (state_d == TRACK);
      vld_d      = (state_d == DONE);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         for (int c = 0; c < NUM_FIFOS; c++) count_q[c] <= '0;
         total_q        <= '0;
         ahead_q        <= '0;
         tracked_sel_q  <= '0;
         tracked_data_q <= '0;
         captured_q     <= '0;
         err_q          <= 1'b0;
         tracking_q     <= 1'b0;
         vld_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         for (int c = 0; c < NUM_FIFOS; c++) count_q[c] <= count_d[c];
         total_q        <= total_d;
         ahead_q        <= ahead_d;
         tracked_sel_q  <= tracked_sel_d;
         tracked_data_q <= tracked_data_d;
         captured_q     <= captured_d;
         err_q          <= err_d;
         tracking_q     <= tracking_d;
         vld_q          <= vld_d;
      end
   end

   for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_flat
      assign count_flat[g*CW +: CW] = count_q[g];
   end

   assign total        = total_q;
   assign tracking     = tracking_q;
   assign data_out_vld = vld_q;
   assign prop_signal  = ~vld_q | (captured_q == tracked_data_q);
   assign protocol_err = err_q;

endmodule

// File: tb/tb_shared_fifo_tracker.sv
// Bench for shared_fifo_tracker: directed scenarios plus random traffic
// against a reference that keeps the real FIFO contents in per-channel queues
// and marks the tagged entry, so the tagged pop is found by queue position.
module tb_shared_fifo_tracker;

   localparam int W  = 4;
   localparam int D  = 4;
   localparam int NF = 2;
   localparam int PW = 2;
   localparam int SW = 1;
   localparam int CW = PW + 1;

   logic               clk = 1'b0;
   logic               rst, push, pop, start;
   logic [SW-1:0]      push_sel, pop_sel, watch_sel;
   logic [W-1:0]       data_in, data_out;
   logic [NF*CW-1:0]   count_flat;
   logic [CW-1:0]      total;
   logic               tracking, data_out_vld, prop_signal, protocol_err;

   int n_checks = 0;
   int n_errors = 0;

   // reference state
   logic [W-1:0] fq_d [NF][$];
   bit           fq_t [NF][$];
   int           m_state;     // 0 idle, 1 tracking, 2 done
   logic [W-1:0] m_tdata, m_cap;
   bit           m_err;

   shared_fifo_tracker #(.WIDTH(W), .DEPTH(D), .NUM_FIFOS(NF)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop),
      .push_sel(push_sel), .pop_sel(pop_sel),
      .data_in(data_in), .data_out(data_out),
      .start(start), .watch_sel(watch_sel),
      .count_flat(count_flat), .total(total),
      .tracking(tracking), .data_out_vld(data_out_vld),
      .prop_signal(prop_signal), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int tot;
      tot = 0;
      for (int c = 0; c < NF; c++) begin
         chk($sformatf("count%0d", c), int'(count_flat[c*CW +: CW]), fq_d[c].size());
         tot += fq_d[c].size();
      end
      chk("total", int'(total), tot);
      chk("tracking", int'(tracking), int'(m_state == 1));
      chk("data_out_vld", int'(data_out_vld), int'(m_state == 2));
      chk("prop_signal", int'(prop_signal), int'(m_state != 2 || m_cap == m_tdata));
      chk("protocol_err", int'(protocol_err), int'(m_err));
   endtask

   task automatic idle_inputs();
      push = 0; pop = 0; start = 0;
      push_sel = '0; pop_sel = '0; watch_sel = '0;
      data_in = '0; data_out = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      for (int c = 0; c < NF; c++) begin
         fq_d[c].delete();
         fq_t[c].delete();
      end
      m_state = 0; m_tdata = '0; m_cap = '0; m_err = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      check_all();
   endtask

   // One cycle: drive inputs, advance the reference, check after the edge.
   task automatic step(input bit pu, input bit po, input int ps, input int qs,
                       input logic [W-1:0] di, input logic [W-1:0] dout,
                       input bit st, input int ws);
      bit pv, ov, tg, arm;
      int tot;
      logic [W-1:0] dd;
      push = pu; pop = po; push_sel = SW'(ps); pop_sel = SW'(qs);
      data_in = di; data_out = dout; start = st; watch_sel = SW'(ws);
      tot = 0;
      for (int c = 0; c < NF; c++) tot += fq_d[c].size();
      pv = pu && (ps < NF) && (tot < D);
      ov = po && (qs < NF);
      if (ov) ov = (fq_d[qs].size() > 0);
      if ((pu && !pv) || (po && !ov)) m_err = 1;
      if (ov) begin
         dd = fq_d[qs].pop_front();
         tg = fq_t[qs].pop_front();
         if (tg && m_state == 1) begin
            m_cap = dout;
            m_state = 2;
         end
      end
      if (pv) begin
         arm = (m_state == 0) && st && (ps == ws);
         fq_d[ps].push_back(di);
         fq_t[ps].push_back(arm);
         if (arm) begin
            m_state = 1;
            m_tdata = di;
         end
      end
      @(posedge clk); #1;
      check_all();
   endtask

   task automatic nop();
      step(0, 0, 0, 0, '0, '0, 0, 0);
   endtask

   function automatic logic [W-1:0] head_or_rand(input int ch);
      logic [W-1:0] v;
      v = W'($urandom);
      if (fq_d[ch].size() > 0) v = fq_d[ch][0];
      return v;
   endfunction

   initial begin
      rst = 1'b0;
      idle_inputs();
      @(posedge clk); #1;

      // reset and idle
      do_reset();
      repeat (3) nop();

      // tagged entry behind one older entry, clean data
      step(1, 0, 1, 0, 4'hA, 4'h0, 0, 0);
      step(1, 0, 1, 0, 4'h5, 4'h0, 1, 1);
      chk("armed_tracking", int'(tracking), 1);
      step(0, 1, 0, 1, 4'h0, 4'hA, 0, 0);
      chk("still_tracking", int'(tracking), 1);
      step(0, 1, 0, 1, 4'h0, 4'h5, 0, 0);
      chk("vld_after_pop", int'(data_out_vld), 1);
      chk("prop_good", int'(prop_signal), 1);
      nop();
      chk("done_sticky", int'(data_out_vld), 1);

      // same, corrupted tagged data
      do_reset();
      step(1, 0, 1, 0, 4'hA, 4'h0, 0, 0);
      step(1, 0, 1, 0, 4'h5, 4'h0, 1, 1);
      step(0, 1, 0, 1, 4'h0, 4'hA, 0, 0);
      step(0, 1, 0, 1, 4'h0, 4'h6, 0, 0);
      chk("vld_bad", int'(data_out_vld), 1);
      chk("prop_bad", int'(prop_signal), 0);

      // arm with simultaneous pop on same channel, side traffic on ch1
      do_reset();
      step(1, 0, 0, 0, 4'h1, 4'h0, 0, 0);
      step(1, 0, 0, 0, 4'h2, 4'h0, 0, 0);
      step(1, 1, 0, 0, 4'h3, 4'h1, 1, 0);
      chk("arm_pop_count0", int'(count_flat[0 +: CW]), 2);
      step(1, 0, 1, 0, 4'h7, 4'h0, 0, 0);
      step(1, 1, 1, 1, 4'h8, 4'h7, 0, 0);
      step(0, 1, 0, 1, 4'h0, 4'h8, 0, 0);
      step(0, 1, 0, 0, 4'h0, 4'h2, 0, 0);
      chk("ahead_kept", int'(tracking), 1);
      step(0, 1, 0, 0, 4'h0, 4'h3, 0, 0);
      chk("arm_pop_vld", int'(data_out_vld), 1);
      chk("arm_pop_prop", int'(prop_signal), 1);

      // overfull push, empty pop, reset clears error
      do_reset();
      for (int i = 0; i < D; i++) step(1, 0, i % NF, 0, W'(i), 4'h0, 0, 0);
      step(1, 0, 0, 0, 4'hF, 4'h0, 0, 0);
      chk("full_err", int'(protocol_err), 1);
      chk("full_total", int'(total), D);
      do_reset();
      step(0, 1, 0, 1, 4'h0, 4'h0, 0, 0);
      chk("empty_err", int'(protocol_err), 1);
      chk("empty_total", int'(total), 0);
      do_reset();
      chk("err_cleared", int'(protocol_err), 0);

      // reset mid-track, then re-arm
      step(1, 0, 0, 0, 4'h9, 4'h0, 1, 0);
      chk("mid_track", int'(tracking), 1);
      do_reset();
      chk("rst_track", int'(tracking), 0);
      chk("rst_total", int'(total), 0);
      step(1, 0, 1, 0, 4'hC, 4'h0, 1, 1);
      chk("rearm", int'(tracking), 1);
      step(0, 1, 0, 1, 4'h0, 4'hC, 0, 0);
      chk("rearm_prop", int'(prop_signal), 1);
      chk("rearm_vld", int'(data_out_vld), 1);

      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit pu, po, st;
         int ps, qs, ws;
         logic [W-1:0] di, dout;
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            pu = ($urandom_range(0, 99) < 45);
            po = ($urandom_range(0, 99) < 45);
            ps = $urandom_range(0, NF - 1);
            qs = $urandom_range(0, NF - 1);
            ws = $urandom_range(0, NF - 1);
            st = ($urandom_range(0, 9) < 2);
            di = W'($urandom);
            dout = head_or_rand(qs);
            if ($urandom_range(0, 7) == 0) dout = dout ^ W'(1 << $urandom_range(0, W - 1));
            step(pu, po, ps, qs, di, dout, st, ws);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
